// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/writeback
// and drives datapath mux selects, ALU operation and write strobes.
// Optional feature macro: CTRL_TRAP_EN. When it is defined, an illegal
// instruction parks the FSM in TRAP with illegal_instr high until reset.
// When it is undefined, an illegal instruction retires as a NOP in DECODE.
module riscv_multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       regWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       WD3Src,
  output logic       PC4Write,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done
`ifdef CTRL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JUMP1, S_JUMP2, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

`ifdef CTRL_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif

  state_t state, state_nxt;

  logic is_load, is_store, is_r, is_i, is_br, is_jal, is_jalr, is_lui;
  logic op_known, f3_legal, illegal;
  logic [2:0] alu_sel;
  logic unused_f7;

  assign is_load  = (OP == OP_LOAD);
  assign is_store = (OP == OP_STORE);
  assign is_r     = (OP == OP_R);
  assign is_i     = (OP == OP_I);
  assign is_br    = (OP == OP_BR);
  assign is_jal   = (OP == OP_JAL);
  assign is_jalr  = (OP == OP_JALR);
  assign is_lui   = (OP == OP_LUI);
  assign op_known = is_load | is_store | is_r | is_i | is_br | is_jal | is_jalr | is_lui;
  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  // ALU operation from funct3; funct7[5] selects sub only for register-register ops
  always_comb begin
    f3_legal = 1'b1;
    alu_sel  = 3'b000;
    case (funct3)
      3'b000:  alu_sel = (is_r && funct7[5]) ? 3'b001 : 3'b000;
      3'b111:  alu_sel = 3'b010;
      3'b110:  alu_sel = 3'b011;
      3'b100:  alu_sel = 3'b100;
      3'b010:  alu_sel = 3'b101;
      default: f3_legal = 1'b0;
    endcase
  end

  assign illegal = !op_known || ((is_r || is_i) && !f3_legal);

  // State register; asynchronous reset returns to FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // Next-state sequencing
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (illegal)                   state_nxt = ILL_NEXT;
        else if (is_load || is_store)  state_nxt = S_MEMADR;
        else if (is_r)                 state_nxt = S_EXECR;
        else if (is_i)                 state_nxt = S_EXECI;
        else if (is_br)                state_nxt = S_BRANCH;
        else if (is_jal || is_jalr)    state_nxt = S_JUMP1;
        else                           state_nxt = S_LUI;
      end
      S_MEMADR:  state_nxt = is_load ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_nxt = S_MEMWB;
      S_EXECR,
      S_EXECI:   state_nxt = S_ALUWB;
      S_JUMP1:   state_nxt = S_JUMP2;
      S_TRAP:    state_nxt = S_TRAP;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Per-state outputs; everything is held low while reset is asserted
  always_comb begin
    regWrite   = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    WD3Src     = 1'b0;
    PC4Write   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = 3'b000;
    instr_done = 1'b0;
`ifdef CTRL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    if (rst) begin
      case (state)
        S_FETCH: begin
          IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01; ALUSrcB = 2'b01; ImmSrc = 3'b010;
`ifndef CTRL_TRAP_EN
          instr_done = illegal;
`endif
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = is_store ? 3'b001 : 3'b000;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = 2'b01; regWrite = 1'b1; instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc = 1'b1; MemWrite = 1'b1; instr_done = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10; ALUControl = alu_sel;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = alu_sel;
        end
        S_ALUWB: begin
          regWrite = 1'b1; instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 2'b10; ALUControl = 3'b110; PCWrite = Zero; instr_done = 1'b1;
        end
        S_JUMP1: begin
          ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; PC4Write = 1'b1;
        end
        S_JUMP2: begin
          ALUSrcA  = is_jalr ? 2'b10 : 2'b01;
          ImmSrc   = is_jalr ? 3'b000 : 3'b011;
          ALUSrcB  = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1;
          regWrite = 1'b1; WD3Src = 1'b1; instr_done = 1'b1;
        end
        S_LUI: begin
          ImmSrc = 3'b100; ResultSrc = 2'b11; regWrite = 1'b1; instr_done = 1'b1;
        end
`ifdef CTRL_TRAP_EN
        S_TRAP: illegal_instr = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/riscv_multicycle_controller.md
RISCV_MULTICYCLE_CONTROLLER -- requirements
Module: riscv_multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs OP[6:0], funct3[2:0] and funct7[6:0], all taken from the decoded instruction register.
REQ-004 SHALL have input Zero, 1 bit: ALU branch condition; 1 = condition true.
REQ-005 SHALL have 1-bit outputs regWrite, PCWrite, AdrSrc, MemWrite, IRWrite, WD3Src and PC4Write.
REQ-006 SHALL have 2-bit outputs ResultSrc, ALUSrcA and ALUSrcB; ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
REQ-007 SHALL use ALUSrcA encoding 00 PC, 01 OldPC, 10 A, and ALUSrcB encoding 00 B register, 01 ImmExt, 10 constant 4.
REQ-008 SHALL have 3-bit output ImmSrc: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-009 SHALL have 3-bit output ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 branch-compare.
REQ-010 SHALL have output instr_done, 1 bit: one-cycle pulse in the final state of each instruction.
REQ-011 SHALL have output illegal_instr, 1 bit: present only with CTRL_TRAP_EN.

Function
REQ-012 SHALL drive every output to 0 in any state unless that state sets it below.
REQ-013 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, PCWrite=1; next state DECODE.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, ALUControl=add; next state by OP: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111/1100111->JUMP1, 0110111->LUI; any other OP -> per REQ-026.
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=I for load / S for store; next MEMREAD (load) or MEMWRITE (store).
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=00; next MEMWB. MEMWB: ResultSrc=01, regWrite=1, instr_done=1; next FETCH.
REQ-017 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, instr_done=1; next FETCH.
REQ-018 EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I. Both next ALUWB.
REQ-019 ALU op decoded from funct3: 000 add, except EXECR with funct7[5]=1 -> sub; 111 and; 110 or; 100 xor; 010 slt; any other funct3 is illegal per REQ-026, with the decision taken in DECODE.
REQ-020 ALUWB: ResultSrc=00, regWrite=1, instr_done=1; next FETCH.
REQ-021 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=110, ResultSrc=00, PCWrite=Zero (combinational), instr_done=1; next FETCH.
REQ-022 JUMP1: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, PC4Write=1; next JUMP2.
REQ-023 JUMP2: ALUSrcB=01, add, ResultSrc=10, PCWrite=1, regWrite=1, WD3Src=1, instr_done=1; next FETCH.
REQ-024 JUMP2 source A: for jal, ALUSrcA=01 and ImmSrc=J; for jalr, ALUSrcA=10 and ImmSrc=I.
REQ-025 LUI: ImmSrc=U, ResultSrc=11, regWrite=1, instr_done=1; next FETCH.
REQ-026 Illegal OP or funct3 in DECODE SHALL follow the Configuration section.
REQ-027 Latency, FETCH inclusive: lui/branch 3 cycles; R/I/store/jal/jalr 4 cycles; load 5 cycles.
REQ-028 Zero SHALL be ignored in every state except BRANCH.

Reset
REQ-029 While rst=0, state SHALL be FETCH and all outputs SHALL be forced to 0, overriding the FETCH decode.
REQ-030 The first FETCH cycle SHALL be the first rising edge after rst deasserts.
REQ-031 Reset mid-instruction SHALL abort immediately, with no further write strobes.

Configuration
REQ-032 With CTRL_TRAP_EN defined, an illegal instruction SHALL go to TRAP, where all strobes are 0 and illegal_instr=1, holding until reset.
REQ-033 Without CTRL_TRAP_EN, an illegal instruction SHALL be a 2-cycle NOP (DECODE -> FETCH, instr_done=1 in DECODE), and the illegal_instr port is absent.

Verification
REQ-034 add (OP=0110011, funct3=000, funct7=0000000) -> FETCH, DECODE, EXECR(ALUControl=000), ALUWB(regWrite=1); exactly one regWrite pulse.
REQ-035 lw (OP=0000011) -> 5 cycles; AdrSrc=1 in MEMREAD; MEMWB has ResultSrc=01 and regWrite=1.
REQ-036 beq: Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> PCWrite=0; 3 cycles in both cases.
REQ-037 jal (OP=1101111) -> PC4Write=1 in JUMP1; JUMP2 has PCWrite=1, regWrite=1, WD3Src=1 and ImmSrc=011.
REQ-038 Drop rst in MEMWRITE -> MemWrite=0 in the same cycle; after release, the FETCH sequence restarts.
REQ-039 OP=1111111: with CTRL_TRAP_EN -> illegal_instr=1 held and no PCWrite; without it -> FETCH after DECODE.
